// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word type, RAM handshake states and arbiter FSM states.
// Sized for the two-core system; the arbiter's round-robin pointer is a single bit.
package cpu_types_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned CPUS         = 2;
    // Address bit that selects word0/word1 of a two-word dcache block
    localparam int unsigned BLK_WORD_BIT = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DSERV,
        ISERV
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_select.sv
// Two-request round-robin picker: the requester named by i_ptr wins ties.
// o_gnt is only meaningful while o_valid is high.
module rr_select (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_valid,
    output logic       o_gnt
);

    always_comb begin
        o_valid = |i_req;
        o_gnt   = i_ptr;
        if (!i_req[i_ptr]) begin
            o_gnt = ~i_ptr;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates two cores' icache/dcache ports onto one RAM port, dcache first, round-robin within
// a class; the grant is held across both words of a dcache block transfer.
module cache_mem_arbiter
    import cpu_types_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    input  logic [CPUS-1:0]     dREN,
    input  logic [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]    daddr,
    input  word_t [CPUS-1:0]    dstore,
    output logic [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]    dload,
    input  logic [CPUS-1:0]     iREN,
    input  word_t [CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]     iwait,
    output word_t [CPUS-1:0]    iload,
    output logic                ramREN,
    output logic                ramWEN,
    output word_t               ramaddr,
    output word_t               ramstore,
    input  word_t               ramload,
    input  ramstate_t           ramstate
);

    arb_state_t r_state, w_state_d;
    logic       r_gnt, w_gnt_d;
    logic       r_rr_ptr, w_rr_ptr_d;
    logic       r_lock, w_lock_d;

    logic [CPUS-1:0] w_dreq;
    logic            w_dvalid, w_dgnt;
    logic            w_ivalid, w_ignt;
    logic            w_access;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == ACCESS);

    rr_select u_dsel (
        .i_req   (w_dreq),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_dvalid),
        .o_gnt   (w_dgnt)
    );

    rr_select u_isel (
        .i_req   (iREN),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_ivalid),
        .o_gnt   (w_ignt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_gnt    <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_lock   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_gnt    <= w_gnt_d;
            r_rr_ptr <= w_rr_ptr_d;
            r_lock   <= w_lock_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_gnt_d    = r_gnt;
        w_rr_ptr_d = r_rr_ptr;
        w_lock_d   = r_lock;
        dwait      = '1;
        iwait      = '1;
        dload      = '0;
        iload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (r_state)
            IDLE: begin
                if (w_dvalid) begin
                    w_state_d = DSERV;
                    w_gnt_d   = w_dgnt;
                end else if (w_ivalid) begin
                    w_state_d = ISERV;
                    w_gnt_d   = w_ignt;
                end
            end

            DSERV: begin
                // REN together with WEN is resolved as a write
                ramWEN   = dWEN[r_gnt];
                ramREN   = dREN[r_gnt] & ~dWEN[r_gnt];
                ramaddr  = daddr[r_gnt];
                ramstore = dstore[r_gnt];
                if (!w_dreq[r_gnt]) begin
                    // Request withdrawn (aborted block): release without touching rr_ptr
                    w_state_d = IDLE;
                    w_lock_d  = 1'b0;
                end else if (w_access) begin
                    dwait[r_gnt] = 1'b0;
                    dload[r_gnt] = ramload;
                    if (daddr[r_gnt][BLK_WORD_BIT]) begin
                        w_state_d  = IDLE;
                        w_lock_d   = 1'b0;
                        w_rr_ptr_d = ~r_rr_ptr;
                    end else begin
                        w_lock_d = 1'b1;
                    end
                end
            end

            ISERV: begin
                ramREN  = iREN[r_gnt];
                ramaddr = iaddr[r_gnt];
                if (!iREN[r_gnt]) begin
                    w_state_d = IDLE;
                end else if (w_access) begin
                    iwait[r_gnt] = 1'b0;
                    iload[r_gnt] = ramload;
                    w_rr_ptr_d   = ~r_rr_ptr;
                    w_state_d    = IDLE;
                end
            end

            default: begin
                w_state_d = IDLE;
                w_lock_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal expectations, then
// randomized cache/RAM traffic compared every cycle against a requester-level reference model.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] dREN, dWEN, iREN;
    word_t [1:0] daddr, dstore, iaddr;
    logic [1:0] dwait, iwait;
    word_t [1:0] dload, iload;
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    ramstate_t  ramstate;

    always #5 CLK = ~CLK;

    cache_mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    int checks   = 0;
    int failures = 0;

    // Model: owner -1 = nobody, 0/1 = dcache of core n, 2/3 = icache of core n-2
    int   m_owner, n_owner;
    logic m_ptr, n_ptr;
    logic [1:0]  e_dwait, e_iwait;
    word_t [1:0] e_dload, e_iload;
    logic        e_ren, e_wen;
    word_t       e_addr, e_store;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(input int r);
        if (r < 2) return dREN[r] || dWEN[r];
        return iREN[r-2];
    endfunction

    // dcache class before icache class; inside a class the pointed-to core goes first
    function automatic int pick();
        int p = int'(m_ptr);
        int ord[4];
        ord[0] = p;
        ord[1] = 1 - p;
        ord[2] = 2 + p;
        ord[3] = 3 - p;
        for (int k = 0; k < 4; k++) begin
            if (pending(ord[k])) return ord[k];
        end
        return -1;
    endfunction

    task automatic settle();
        int g;
        #1;
        e_dwait = '1; e_iwait = '1; e_dload = '0; e_iload = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
        n_owner = m_owner;
        n_ptr   = m_ptr;
        if (m_owner < 0) begin
            n_owner = pick();
        end else if (m_owner < 2) begin
            g       = m_owner;
            e_wen   = dWEN[g];
            e_ren   = dREN[g] && !dWEN[g];
            e_addr  = daddr[g];
            e_store = dstore[g];
            if (!(dREN[g] || dWEN[g])) begin
                n_owner = -1;
            end else if (ramstate == ACCESS) begin
                e_dwait[g] = 1'b0;
                e_dload[g] = ramload;
                if (daddr[g][2]) begin
                    n_owner = -1;
                    n_ptr   = !m_ptr;
                end
            end
        end else begin
            g      = m_owner - 2;
            e_ren  = iREN[g];
            e_addr = iaddr[g];
            if (!iREN[g]) begin
                n_owner = -1;
            end else if (ramstate == ACCESS) begin
                e_iwait[g] = 1'b0;
                e_iload[g] = ramload;
                n_ptr      = !m_ptr;
                n_owner    = -1;
            end
        end
        chk("dwait", dwait, e_dwait);
        chk("iwait", iwait, e_iwait);
        chk("dload0", dload[0], e_dload[0]);
        chk("dload1", dload[1], e_dload[1]);
        chk("iload0", iload[0], e_iload[0]);
        chk("iload1", iload[1], e_iload[1]);
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
    endtask

    task automatic advance();
        @(posedge CLK);
        m_owner = n_owner;
        m_ptr   = n_ptr;
        @(negedge CLK);
    endtask

    initial begin
        int gap[4];
        bit blk[2];
        int unsigned r;

        dREN = '0; dWEN = '0; iREN = '0;
        daddr = '0; dstore = '0; iaddr = '0;
        ramload = '0; ramstate = FREE;
        m_owner = -1; m_ptr = 1'b0;
        e_dwait = '1; e_iwait = '1;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_ramREN", ramREN, 1'b0);
        chk("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_dload0", dload[0], 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        settle(); advance();

        // Priority / round-robin: d0, d1, then i0 (rr_ptr = 0)
        dREN = 2'b11; daddr[0] = 32'h14; daddr[1] = 32'h24;
        iREN = 2'b01; iaddr[0] = 32'h30; ramstate = ACCESS; ramload = 32'hA0;
        settle(); chk("c_idle_ramREN", ramREN, 1'b0); advance();
        settle(); chk("c_d0_wait", dwait, 2'b10); chk("c_d0_addr", ramaddr, 32'h14); advance();
        dREN[0] = 1'b0; settle(); advance();
        settle(); chk("c_d1_wait", dwait, 2'b01); chk("c_d1_addr", ramaddr, 32'h24); advance();
        dREN[1] = 1'b0; settle(); advance();
        settle(); chk("c_i0_wait", iwait, 2'b10); chk("c_i0_addr", ramaddr, 32'h30); advance();
        iREN = '0; settle(); advance();

        // Single icache read, two BUSY cycles then ACCESS
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = BUSY;
        settle(); advance();
        settle(); chk("a_ramREN", ramREN, 1'b1); chk("a_addr", ramaddr, 32'h40);
        chk("a_wait_busy", iwait, 2'b11); advance();
        settle(); advance();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        settle(); chk("a_iwait", iwait, 2'b10); chk("a_iload", iload[0], 32'hDEADBEEF); advance();
        iREN = '0; ramstate = FREE;
        settle(); chk("a_ramREN_off", ramREN, 1'b0); chk("a_iload_off", iload[0], 32'h0);
        advance();

        // Dcache block writeback with a competing icache request
        dWEN[0] = 1'b1; daddr[0] = 32'h100; dstore[0] = 32'h1111;
        iREN[1] = 1'b1; iaddr[1] = 32'h80; ramstate = ACCESS;
        settle(); advance();
        settle(); chk("b_w0_wen", ramWEN, 1'b1); chk("b_w0_addr", ramaddr, 32'h100);
        chk("b_w0_store", ramstore, 32'h1111); chk("b_w0_iwait", iwait, 2'b11); advance();
        daddr[0] = 32'h104; dstore[0] = 32'h2222;
        settle(); chk("b_w1_addr", ramaddr, 32'h104); chk("b_w1_dwait", dwait, 2'b10);
        chk("b_w1_iwait", iwait, 2'b11); advance();
        dWEN = '0; settle(); chk("b_gap_iwait", iwait, 2'b11); advance();
        settle(); chk("b_i1_iwait", iwait, 2'b01); chk("b_i1_addr", ramaddr, 32'h80); advance();
        iREN = '0; settle(); advance();

        // Aborted block: core1 reads word0 then withdraws; icache0 served two cycles later
        dREN[1] = 1'b1; daddr[1] = 32'h208; iREN[0] = 1'b1; iaddr[0] = 32'h50;
        ramstate = ACCESS; ramload = 32'h5A5A;
        settle(); advance();
        settle(); chk("d_dwait", dwait, 2'b01); chk("d_dload", dload[1], 32'h5A5A); advance();
        dREN[1] = 1'b0; ramstate = BUSY;
        settle(); chk("d_abort_ren", ramREN, 1'b0); advance();
        settle(); advance();
        ramstate = ACCESS;
        settle(); chk("d_i0_addr", ramaddr, 32'h50); chk("d_i0_wait", iwait, 2'b10); advance();
        iREN = '0; settle(); advance();

        // ERROR is retried with the address held
        dREN[0] = 1'b1; daddr[0] = 32'h304; ramstate = ERROR;
        settle(); advance();
        for (int k = 0; k < 3; k++) begin
            settle(); chk("e_dwait_err", dwait, 2'b11); chk("e_addr_err", ramaddr, 32'h304);
            advance();
        end
        ramstate = ACCESS;
        settle(); chk("e_dwait_acc", dwait, 2'b10); chk("e_addr_acc", ramaddr, 32'h304); advance();
        dREN = '0; settle(); chk("e_dwait_done", dwait, 2'b11); advance();

        // Asynchronous reset during a RAM write
        dWEN[0] = 1'b1; daddr[0] = 32'h400; dstore[0] = 32'hCAFE; ramstate = BUSY;
        settle(); advance();
        settle(); chk("f_wen_before", ramWEN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        chk("f_wen_rst", ramWEN, 1'b0);
        chk("f_dwait_rst", dwait, 2'b11);
        chk("f_iwait_rst", iwait, 2'b11);
        chk("f_addr_rst", ramaddr, 32'h0);
        m_owner = -1; m_ptr = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        settle(); chk("f_idle_wen", ramWEN, 1'b0); advance();
        settle(); chk("f_wen_again", ramWEN, 1'b1); advance();
        ramstate = ACCESS;
        settle(); chk("f_dwait_acc", dwait, 2'b10); advance();
        dWEN = '0; settle(); advance();

        // Randomized traffic
        for (int k = 0; k < 4; k++) gap[k] = 0;
        blk[0] = 1'b0; blk[1] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (dREN[k] || dWEN[k]) begin
                    if (!e_dwait[k]) begin
                        if (blk[k] && !daddr[k][2] && $urandom_range(7) != 0) begin
                            daddr[k]  = daddr[k] + 32'd4;
                            dstore[k] = $urandom;
                        end else begin
                            dREN[k] = 1'b0; dWEN[k] = 1'b0;
                            gap[k]  = $urandom_range(3);
                        end
                    end
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end else if ($urandom_range(1) == 1) begin
                    r = $urandom_range(15);
                    if (r == 0) begin
                        dREN[k] = 1'b1; dWEN[k] = 1'b1; blk[k] = 1'b0;
                        daddr[k] = $urandom & 32'hFFFF_FFFC;
                    end else begin
                        dWEN[k]  = r[0];
                        dREN[k]  = !r[0];
                        blk[k]   = r[1];
                        daddr[k] = r[1] ? ($urandom & 32'hFFFF_FFF8) : ($urandom & 32'hFFFF_FFFC);
                    end
                    dstore[k] = $urandom;
                end

                if (iREN[k]) begin
                    if (!e_iwait[k] || $urandom_range(31) == 0) begin
                        iREN[k]    = 1'b0;
                        gap[2 + k] = $urandom_range(3);
                    end
                end else if (gap[2 + k] > 0) begin
                    gap[2 + k]--;
                end else if ($urandom_range(1) == 1) begin
                    iREN[k]  = 1'b1;
                    iaddr[k] = $urandom & 32'hFFFF_FFFC;
                end
            end
            r = $urandom_range(7);
            if (r < 4)       ramstate = ACCESS;
            else if (r < 6)  ramstate = BUSY;
            else if (r == 6) ramstate = ERROR;
            else             ramstate = FREE;
            ramload = $urandom;
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
